// File: rtl/cp0_ctrl.sv
// cp0_ctrl: MIPS coprocessor-0 control (SR, Cause, EPC, PRId), interrupt and
// exception entry arbitration, pipeline flush/redirect, mfc0/mtc0 and eret.
// Optional timer (Count/Compare) is enabled by defining CP0_TIMER_EN.
module cp0_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  HWInt,
    input  logic [4:0]  ExcCode_MEM,
    input  logic [31:0] PC_EPC,
    input  logic        Delay_Set,
    input  logic        EXLClr,
    input  logic [4:0]  CP0_RW_Addr,
    input  logic        CP0_WE,
    input  logic [31:0] CP0_WData,
    output logic [31:0] CP0_RData,
    output logic [31:0] EPC_Out,
    output logic        EXC_flush,
    output logic [31:0] EXC_PC
);

    localparam logic [31:0] HANDLER_PC   = 32'h0000_4180;
    localparam logic [31:0] PRID_VAL     = 32'h5037_0001;
    localparam logic [4:0]  EXC_NONE     = 5'b11111;
    localparam logic [4:0]  ADDR_COUNT   = 5'd9;
    localparam logic [4:0]  ADDR_COMPARE = 5'd11;
    localparam logic [4:0]  ADDR_SR      = 5'd12;
    localparam logic [4:0]  ADDR_CAUSE   = 5'd13;
    localparam logic [4:0]  ADDR_EPC     = 5'd14;
    localparam logic [4:0]  ADDR_PRID    = 5'd15;

    // State is the SR.EXL bit itself
    typedef enum logic {
        RUN     = 1'b0,
        HANDLER = 1'b1
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [5:0]  im_q;
    logic        ie_q;
    logic [5:0]  ip_q;
    logic [5:0]  ip_d;
    logic        bd_q;
    logic [4:0]  exc_code_q;
    logic [31:0] epc_q;
    logic        exl;
    logic        int_req;
    logic        exc_req;
    logic        flush;
    logic        wr_en;
    logic        sr_we;

`ifdef CP0_TIMER_EN
    logic [31:0] count_q;
    logic [31:0] compare_q;
    logic        ti_q;
`endif

    // EXL state register; reset drops out of the handler immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= RUN;
        else        state_q <= state_d;
    end

    // EXL transitions: entry sets, eret clears and beats a same-cycle mtc0 set
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (flush)
                    state_d = HANDLER;
                else if (sr_we && CP0_WData[1] && !EXLClr)
                    state_d = HANDLER;
            end
            HANDLER: begin
                if (EXLClr || (sr_we && !CP0_WData[1]))
                    state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // Request arbitration, flush and write qualification
    always_comb begin
        exl     = 1'b0;
        int_req = 1'b0;
        exc_req = 1'b0;
        flush   = 1'b0;
        wr_en   = 1'b0;
        sr_we   = 1'b0;
        exl     = (state_q == HANDLER);
        int_req = (|(ip_q & im_q)) & ie_q & !exl;
        exc_req = (ExcCode_MEM != EXC_NONE) & !exl;
        flush   = (int_req | exc_req) & reset;
        wr_en   = CP0_WE & !flush;
        sr_we   = wr_en & (CP0_RW_Addr == ADDR_SR);
    end

    // Pending interrupt lines, timer interrupt folded into the top line
    always_comb begin
        ip_d = HWInt;
`ifdef CP0_TIMER_EN
        ip_d[5] = HWInt[5] | ti_q;
`endif
    end

    // SR/Cause/EPC: entry capture has priority over mtc0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im_q       <= 6'd0;
            ie_q       <= 1'b0;
            ip_q       <= 6'd0;
            bd_q       <= 1'b0;
            exc_code_q <= 5'd0;
            epc_q      <= 32'd0;
        end else begin
            ip_q <= ip_d;
            if (flush) begin
                epc_q      <= PC_EPC;
                bd_q       <= Delay_Set;
                exc_code_q <= int_req ? 5'd0 : ExcCode_MEM;
            end else if (wr_en) begin
                if (CP0_RW_Addr == ADDR_SR) begin
                    im_q <= CP0_WData[15:10];
                    ie_q <= CP0_WData[0];
                end
                if (CP0_RW_Addr == ADDR_EPC)
                    epc_q <= CP0_WData;
            end
        end
    end

`ifdef CP0_TIMER_EN
    // Free-running Count, Compare match raises TI until Compare is rewritten
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            ti_q      <= 1'b0;
        end else begin
            if (wr_en && (CP0_RW_Addr == ADDR_COUNT))
                count_q <= CP0_WData;
            else
                count_q <= count_q + 32'd1;
            if (wr_en && (CP0_RW_Addr == ADDR_COMPARE)) begin
                compare_q <= CP0_WData;
                ti_q      <= 1'b0;
            end else if ((count_q == compare_q) && (compare_q != 32'd0)) begin
                ti_q <= 1'b1;
            end
        end
    end
`endif

    // mfc0 read mux and constant/continuous outputs
    always_comb begin
        CP0_RData = 32'd0;
        case (CP0_RW_Addr)
            ADDR_SR:    CP0_RData = {16'd0, im_q, 8'd0, exl, ie_q};
            ADDR_CAUSE: CP0_RData = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'd0};
            ADDR_EPC:   CP0_RData = epc_q;
            ADDR_PRID:  CP0_RData = PRID_VAL;
`ifdef CP0_TIMER_EN
            ADDR_COUNT:   CP0_RData = count_q;
            ADDR_COMPARE: CP0_RData = compare_q;
`endif
            default:    CP0_RData = 32'd0;
        endcase
        EPC_Out   = epc_q;
        EXC_flush = flush;
        EXC_PC    = HANDLER_PC;
    end

endmodule
